// File: rtl/elevator_scheduler.sv
// SCAN/collective car-motion controller for a 7-floor, 2-way elevator.
// Sequences idle, travel, arrival, door-open and decide phases from latched hall and cab calls.
module elevator_scheduler #(
   parameter int unsigned FLOOR_TICKS = 8,
   parameter int unsigned DOOR_TICKS  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] floorButton,
   input  logic [9:1]  internalButton,
   output logic [2:0]  currentFloor,
   output logic [1:0]  currentDirection,
   output logic        doorState,
   output logic        move,
   output logic        buttonEnable
);

   localparam int unsigned TW = $clog2(FLOOR_TICKS);
   localparam int unsigned DW = $clog2(DOOR_TICKS);

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      ARRIVE,
      DOOR_OPEN,
      DECIDE
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [TW-1:0] travel_cnt;
   logic [TW-1:0] next_travel_cnt;
   logic [DW-1:0] door_cnt;
   logic [DW-1:0] next_door_cnt;
   logic [2:0]    next_floor;
   logic [1:0]    next_dir;
   logic [1:0]    flipped_dir;

   logic [7:0] up_call;
   logic [7:0] down_call;
   logic [7:0] cab_call;
   logic [7:0] any_call;
   logic       cab_here;
   logic       up_here;
   logic       down_here;
   logic       here;
   logic       above;
   logic       below;
   logic       ahead;
   logic       behind;
   logic       same_here;
   logic       opp_here;
   logic       unused_cab;

   // Cab calls for floors 8 and 9 do not exist on this car.
   assign unused_cab = ^internalButton[9:8];

   // Per-floor call vectors indexed directly by floor number; bit 0 is never a floor.
   always_comb begin : decode
      up_call   = '0;
      down_call = '0;
      cab_call  = '0;
      for (int f = 1; f <= 7; f++) begin
         up_call[f]   = floorButton[2*f-2];
         down_call[f] = floorButton[2*f-1];
         cab_call[f]  = internalButton[f];
      end
      any_call = up_call | down_call | cab_call;
   end

   always_comb begin : position
      above = 1'b0;
      below = 1'b0;
      for (int f = 1; f <= 7; f++) begin
         if (3'(f) > currentFloor) above = above | any_call[f];
         if (3'(f) < currentFloor) below = below | any_call[f];
      end
   end

   assign cab_here    = cab_call[currentFloor];
   assign up_here     = up_call[currentFloor];
   assign down_here   = down_call[currentFloor];
   assign flipped_dir = {currentDirection[0], currentDirection[1]};

   // With no direction, "ahead" means up so that up wins ties.
   always_comb begin : relative
      here = cab_here | up_here | down_here;
      if (currentDirection == DIR_UP)   here = cab_here | up_here;
      if (currentDirection == DIR_DOWN) here = cab_here | down_here;
      ahead     = (currentDirection == DIR_DOWN) ? below : above;
      behind    = (currentDirection == DIR_DOWN) ? above : below;
      same_here = (currentDirection == DIR_DOWN) ? down_here : up_here;
      opp_here  = (currentDirection == DIR_DOWN) ? up_here : down_here;
   end

   always_comb begin : next_logic
      next_state      = state;
      next_floor      = currentFloor;
      next_dir        = currentDirection;
      next_travel_cnt = '0;
      next_door_cnt   = '0;
      case (state)
         IDLE: begin
            if (here) begin
               next_state = DOOR_OPEN;
               if (up_here)        next_dir = DIR_UP;
               else if (down_here) next_dir = DIR_DOWN;
               else                next_dir = DIR_NONE;
            end else if (above) begin
               next_state = MOVE_UP;
               next_dir   = DIR_UP;
            end else if (below) begin
               next_state = MOVE_DOWN;
               next_dir   = DIR_DOWN;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            if (travel_cnt == TW'(FLOOR_TICKS - 1)) begin
               next_floor = (state == MOVE_UP) ? currentFloor + 3'd1 : currentFloor - 3'd1;
               next_state = ARRIVE;
            end else begin
               next_travel_cnt = travel_cnt + TW'(1);
            end
         end
         ARRIVE: begin
            if (cab_here || same_here || !ahead) begin
               next_state = DOOR_OPEN;
               // Turn around for a lone opposite hall call at the end of the run.
               if (!ahead && opp_here && !cab_here && !same_here) next_dir = flipped_dir;
            end else begin
               next_state = (currentDirection == DIR_DOWN) ? MOVE_DOWN : MOVE_UP;
            end
         end
         DOOR_OPEN: begin
            if (here) begin
               next_door_cnt = '0;
            end else if (door_cnt == DW'(DOOR_TICKS - 1)) begin
               next_state = DECIDE;
            end else begin
               next_door_cnt = door_cnt + DW'(1);
            end
         end
         DECIDE: begin
            if (ahead) begin
               next_dir   = (currentDirection == DIR_DOWN) ? DIR_DOWN : DIR_UP;
               next_state = (currentDirection == DIR_DOWN) ? MOVE_DOWN : MOVE_UP;
            end else if (behind) begin
               next_dir   = (currentDirection == DIR_DOWN) ? DIR_UP : DIR_DOWN;
               next_state = (currentDirection == DIR_DOWN) ? MOVE_UP : MOVE_DOWN;
            end else if (here) begin
               next_state = DOOR_OPEN;
            end else begin
               next_state = IDLE;
               next_dir   = DIR_NONE;
            end
         end
         default: begin
            next_state = IDLE;
            next_dir   = DIR_NONE;
         end
      endcase
   end

   // Door and move flags follow the state being entered, so they are valid with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         travel_cnt       <= '0;
         door_cnt         <= '0;
         currentFloor     <= 3'd1;
         currentDirection <= DIR_NONE;
         doorState        <= 1'b0;
         move             <= 1'b0;
         buttonEnable     <= 1'b0;
      end else begin
         state            <= next_state;
         travel_cnt       <= next_travel_cnt;
         door_cnt         <= next_door_cnt;
         currentFloor     <= next_floor;
         currentDirection <= next_dir;
         doorState        <= (next_state == DOOR_OPEN);
         move             <= (next_state == MOVE_UP) || (next_state == MOVE_DOWN) ||
                             (next_state == ARRIVE);
         buttonEnable     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls against a phase/countdown model.
// The bench also plays the button register, dropping calls served while the door is open.
module tb_elevator_scheduler;

   localparam int FT = 4;
   localparam int DT = 3;

   localparam int P_IDLE   = 0;
   localparam int P_TRAVEL = 1;
   localparam int P_ARRIVE = 2;
   localparam int P_DOOR   = 3;
   localparam int P_DECIDE = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] floorButton;
   logic [9:1]  internalButton;
   logic [2:0]  currentFloor;
   logic [1:0]  currentDirection;
   logic        doorState;
   logic        move;
   logic        buttonEnable;

   int errors;
   int checks;
   int m_phase;
   int m_floor;
   int m_dir;
   int m_left;
   bit m_be;
   bit auto_clear;

   elevator_scheduler #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
      .clk              (clk),
      .reset            (reset),
      .floorButton      (floorButton),
      .internalButton   (internalButton),
      .currentFloor     (currentFloor),
      .currentDirection (currentDirection),
      .doorState        (doorState),
      .move             (move),
      .buttonEnable     (buttonEnable)
   );

   always #5 clk = ~clk;

   function automatic bit cab(input int f);
      return internalButton[f];
   endfunction

   function automatic bit hup(input int f);
      return floorButton[2*f-2];
   endfunction

   function automatic bit hdn(input int f);
      return floorButton[2*f-1];
   endfunction

   function automatic bit calls_above(input int f);
      for (int g = f + 1; g <= 7; g++) if (cab(g) || hup(g) || hdn(g)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit calls_below(input int f);
      for (int g = 1; g < f; g++) if (cab(g) || hup(g) || hdn(g)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit here_at(input int f, input int d);
      if (d > 0) return cab(f) || hup(f);
      if (d < 0) return cab(f) || hdn(f);
      return cab(f) || hup(f) || hdn(f);
   endfunction

   function automatic logic [1:0] dir_code(input int d);
      return (d > 0) ? 2'b01 : (d < 0) ? 2'b10 : 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE;
      m_floor = 1;
      m_dir   = 0;
      m_left  = 0;
      m_be    = 1'b0;
   endtask

   // One clock edge of the reference behaviour, using the inputs present at that edge.
   task automatic model_step();
      bit fwd, back, same, opp;
      m_be = 1'b1;
      case (m_phase)
         P_IDLE: begin
            if (here_at(m_floor, 0)) begin
               m_dir   = hup(m_floor) ? 1 : hdn(m_floor) ? -1 : 0;
               m_phase = P_DOOR;
               m_left  = DT;
            end else if (calls_above(m_floor)) begin
               m_dir = 1; m_phase = P_TRAVEL; m_left = FT;
            end else if (calls_below(m_floor)) begin
               m_dir = -1; m_phase = P_TRAVEL; m_left = FT;
            end
         end
         P_TRAVEL: begin
            m_left--;
            if (m_left == 0) begin
               m_floor = m_floor + m_dir;
               m_phase = P_ARRIVE;
            end
         end
         P_ARRIVE: begin
            fwd  = (m_dir > 0) ? calls_above(m_floor) : calls_below(m_floor);
            same = (m_dir > 0) ? hup(m_floor) : hdn(m_floor);
            opp  = (m_dir > 0) ? hdn(m_floor) : hup(m_floor);
            if (cab(m_floor) || same || !fwd) begin
               if (!fwd && opp && !cab(m_floor) && !same) m_dir = -m_dir;
               m_phase = P_DOOR;
               m_left  = DT;
            end else begin
               m_phase = P_TRAVEL;
               m_left  = FT;
            end
         end
         P_DOOR: begin
            if (here_at(m_floor, m_dir)) m_left = DT;
            else begin
               m_left--;
               if (m_left == 0) m_phase = P_DECIDE;
            end
         end
         default: begin
            if (m_dir == 0) begin
               fwd  = calls_above(m_floor);
               back = calls_below(m_floor);
               if (fwd) m_dir = 1;
               else if (back) m_dir = -1;
            end else begin
               fwd  = (m_dir > 0) ? calls_above(m_floor) : calls_below(m_floor);
               back = (m_dir > 0) ? calls_below(m_floor) : calls_above(m_floor);
               if (!fwd && back) m_dir = -m_dir;
            end
            if (fwd || back) begin
               m_phase = P_TRAVEL; m_left = FT;
            end else if (here_at(m_floor, m_dir)) begin
               m_phase = P_DOOR; m_left = DT;
            end else begin
               m_phase = P_IDLE; m_dir = 0;
            end
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_step();
      #1;
      chk("floor", 32'(currentFloor), 32'(m_floor));
      chk("dir", 32'(currentDirection), 32'(dir_code(m_dir)));
      chk("door", 32'(doorState), 32'(m_phase == P_DOOR));
      chk("move", 32'(move), 32'(m_phase == P_TRAVEL || m_phase == P_ARRIVE));
      chk("button_enable", 32'(buttonEnable), 32'(m_be));
      if (auto_clear && m_phase == P_DOOR) begin
         internalButton[m_floor] = 1'b0;
         if (m_dir >= 0) floorButton[2*m_floor-2] = 1'b0;
         if (m_dir <= 0) floorButton[2*m_floor-1] = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_floor", 32'(currentFloor), 32'd1);
      chk("rst_dir", 32'(currentDirection), 32'd0);
      chk("rst_door", 32'(doorState), 32'd0);
      chk("rst_move", 32'(move), 32'd0);
      chk("rst_button_enable", 32'(buttonEnable), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_until_door(input int bound);
      int n = 0;
      while (m_phase == P_DOOR && n < bound) begin tick(); n++; end
      while (m_phase != P_DOOR && n < bound) begin tick(); n++; end
      chk("door_reached", 32'(m_phase == P_DOOR), 32'd1);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (!(m_phase == P_IDLE && floorButton == 14'd0 && internalButton[7:1] == 7'd0)
             && n < bound) begin
         tick(); n++;
      end
      chk("idle_reached", 32'(m_phase == P_IDLE), 32'd1);
   endtask

   initial begin
      int n;
      int r;
      errors         = 0;
      checks         = 0;
      auto_clear     = 1'b1;
      floorButton    = '0;
      internalButton = '0;
      reset          = 1'b0;
      model_reset();
      #1;
      do_reset();

      // Idle with no calls holds at floor 1.
      repeat (3) tick();
      chk("idle_floor", 32'(currentFloor), 32'd1);
      chk("idle_move", 32'(move), 32'd0);

      // Reset while moving up at floor 3.
      internalButton[5] = 1'b1;
      n = 0;
      while (!(m_floor == 3 && m_phase == P_TRAVEL) && n < 40) begin tick(); n++; end
      chk("mid_travel_at_3", 32'(currentFloor), 32'd3);
      internalButton = '0;
      do_reset();
      repeat (4) tick();
      chk("post_reset_floor", 32'(currentFloor), 32'd1);
      chk("post_reset_door", 32'(doorState), 32'd0);

      // Cab call to floor 4 from floor 1: exact cycle timeline.
      internalButton[4] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) begin
            chk("c4_move_start", 32'(move), 32'd1);
            chk("c4_dir_up", 32'(currentDirection), 32'd1);
         end
         if (c == 14) chk("c4_floor3_c14", 32'(currentFloor), 32'd3);
         if (c == 15) chk("c4_floor4_c15", 32'(currentFloor), 32'd4);
         if (c >= 16 && c <= 18) chk("c4_door_open", 32'(doorState), 32'd1);
         if (c == 19) chk("c4_decide_closed", 32'(doorState), 32'd0);
         if (c == 20) begin
            chk("c4_idle_dir", 32'(currentDirection), 32'd0);
            chk("c4_idle_move", 32'(move), 32'd0);
         end
      end

      // Up past floor 3's down call to floor 5, then reverse and serve floor 3.
      internalButton[1] = 1'b1;
      wait_idle(100);
      internalButton[5] = 1'b1;
      floorButton[5]    = 1'b1;
      run_until_door(100);
      chk("scan_first_stop", 32'(currentFloor), 32'd5);
      run_until_door(100);
      chk("scan_second_stop", 32'(currentFloor), 32'd3);
      chk("scan_second_dir", 32'(currentDirection), 32'd2);
      wait_idle(100);

      // Up hall call at the current floor held open, then released.
      auto_clear     = 1'b0;
      floorButton[4] = 1'b1;
      tick();
      chk("hold_door", 32'(doorState), 32'd1);
      chk("hold_dir", 32'(currentDirection), 32'd1);
      repeat (4) begin
         tick();
         chk("hold_extend", 32'(doorState), 32'd1);
      end
      floorButton[4] = 1'b0;
      auto_clear     = 1'b1;
      for (int k = 1; k < DT; k++) begin
         tick();
         chk("hold_tail", 32'(doorState), 32'd1);
      end
      tick();
      chk("hold_closed", 32'(doorState), 32'd0);

      // Calls at 6 and 2 from floor 4: up first.
      internalButton[4] = 1'b1;
      wait_idle(100);
      internalButton[6] = 1'b1;
      internalButton[2] = 1'b1;
      tick();
      chk("split_dir_up", 32'(currentDirection), 32'd1);
      run_until_door(100);
      chk("split_first", 32'(currentFloor), 32'd6);
      run_until_door(100);
      chk("split_second", 32'(currentFloor), 32'd2);
      chk("split_second_dir", 32'(currentDirection), 32'd2);
      wait_idle(100);

      // Top floor: own cab call opens with no direction, then a call at 1 goes down.
      internalButton[7] = 1'b1;
      wait_idle(100);
      internalButton[7] = 1'b1;
      tick();
      chk("top_door", 32'(doorState), 32'd1);
      chk("top_dir_none", 32'(currentDirection), 32'd0);
      wait_idle(100);
      internalButton[1] = 1'b1;
      tick();
      chk("top_down_move", 32'(move), 32'd1);
      chk("top_down_dir", 32'(currentDirection), 32'd2);
      run_until_door(100);
      chk("top_down_floor", 32'(currentFloor), 32'd1);
      wait_idle(100);

      // Random hall and cab calls, including the unused cab bits.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            r = int'($urandom_range(0, 22));
            if (r < 14) floorButton[r] = 1'b1;
            else internalButton[r - 13] = 1'b1;
         end
         if (i == 1000) do_reset();
         tick();
      end
      wait_idle(400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
